// File: rtl/sram_2p_bw_model_pkg.sv
// Shared constants and helpers for the two-port byte-write SRAM model.
// Build option: SRAM_WR_FWD_EN selects write-through on same-address collisions.
package sram_model_pkg;

    localparam int BYTE_W     = 8;
    localparam int RD_LAT_MAX = 4;

    // Address width for a given depth; a one-word array still gets one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sram_2p_bw_model_if.sv
// Write/read request bundle and read response of the two-port SRAM model.
// Master drives requests; slave (the memory) returns data, valid and range error.
interface sram_2p_bw_model_if
    import sram_model_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 64
) ();

    localparam int AW  = clog2(DEPTH);
    localparam int BEW = DATA_WIDTH / BYTE_W;

    logic                  inst_wr_cs_n;
    logic [AW-1:0]         inst_wr_addr;
    logic [DATA_WIDTH-1:0] inst_wr_data;
    logic [BEW-1:0]        inst_wr_be;
    logic                  inst_rd_cs_n;
    logic [AW-1:0]         inst_rd_addr;
    logic [DATA_WIDTH-1:0] data_out_inst;
    logic                  data_out_vld;
    logic                  addr_err;

    modport master (
        output inst_wr_cs_n, inst_wr_addr, inst_wr_data, inst_wr_be,
        output inst_rd_cs_n, inst_rd_addr,
        input  data_out_inst, data_out_vld, addr_err
    );

    modport slave (
        input  inst_wr_cs_n, inst_wr_addr, inst_wr_data, inst_wr_be,
        input  inst_rd_cs_n, inst_rd_addr,
        output data_out_inst, data_out_vld, addr_err
    );

endinterface

// File: rtl/sram_rd_pipe.sv
// Read-data delay line: RD_LAT stages of {vld, data}.
// Latency RD_LAT cycles; no backpressure, one result per cycle in order.
module sram_rd_pipe #(
    parameter int DATA_WIDTH = 512,
    parameter int RD_LAT     = 1
) (
    input  logic                  inst_clk,
    input  logic                  inst_rst_n,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_dat,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_dat
);

    logic [RD_LAT-1:0]     vld_q;
    logic [DATA_WIDTH-1:0] dat_q [RD_LAT];

    // Data only advances with its valid, so the last stage holds between pulses.
    always_ff @(posedge inst_clk or negedge inst_rst_n) begin
        if (!inst_rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= in_vld;
            if (in_vld) dat_q[0] <= in_dat;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[RD_LAT-1];
    assign out_dat = dat_q[RD_LAT-1];

endmodule

// File: rtl/sram_2p_bw_model.sv
// Behavioural 1W+1R SRAM with byte enables, RD_LAT read delay and sticky range error.
// Read data appears RD_LAT cycles after the sampling edge; no backpressure. Option: SRAM_WR_FWD_EN.
module sram_2p_bw_model
    import sram_model_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 64,
    parameter int RD_LAT     = 1
) (
    input  logic                inst_clk,
    input  logic                inst_rst_n,
    sram_2p_bw_model_if.slave   bus
);

    localparam int             AW      = clog2(DEPTH);
    localparam int             BEW     = DATA_WIDTH / BYTE_W;
    localparam logic [AW:0]    DEPTH_W = (AW+1)'(DEPTH);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("sram_2p_bw_model: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
    end

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    logic                  wr_req, rd_req;
    logic                  wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  smp_vld;
    logic [DATA_WIDTH-1:0] smp_dat;
    logic                  err_q;

    assign wr_req = ~bus.inst_wr_cs_n;
    assign rd_req = ~bus.inst_rd_cs_n;
    assign wr_ok  = wr_req && ({1'b0, bus.inst_wr_addr} < DEPTH_W);
    assign rd_ok  = rd_req && ({1'b0, bus.inst_rd_addr} < DEPTH_W);

    always_ff @(posedge inst_clk) begin
        if (wr_ok) begin
            for (int i = 0; i < BEW; i++) begin
                if (bus.inst_wr_be[i])
                    ram[bus.inst_wr_addr][i*BYTE_W +: BYTE_W] <= bus.inst_wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Out-of-range reads return zero; colliding reads see the old word unless forwarding is built in.
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = ram[bus.inst_rd_addr];
`ifdef SRAM_WR_FWD_EN
            if (wr_ok && (bus.inst_wr_addr == bus.inst_rd_addr)) begin
                for (int i = 0; i < BEW; i++) begin
                    if (bus.inst_wr_be[i])
                        rd_word[i*BYTE_W +: BYTE_W] = bus.inst_wr_data[i*BYTE_W +: BYTE_W];
                end
            end
`else
            rd_word = ram[bus.inst_rd_addr];
`endif
        end
    end

    always_ff @(posedge inst_clk or negedge inst_rst_n) begin
        if (!inst_rst_n) begin
            smp_vld <= 1'b0;
            smp_dat <= '0;
            err_q   <= 1'b0;
        end else begin
            smp_vld <= rd_req;
            if (rd_req) smp_dat <= rd_word;
            if ((wr_req && !wr_ok) || (rd_req && !rd_ok)) err_q <= 1'b1;
        end
    end

    assign bus.addr_err = err_q;

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LAT     (RD_LAT)
    ) u_rd_pipe (
        .inst_clk   (inst_clk),
        .inst_rst_n (inst_rst_n),
        .in_vld     (smp_vld),
        .in_dat     (smp_dat),
        .out_vld    (bus.data_out_vld),
        .out_dat    (bus.data_out_inst)
    );

endmodule

// File: tb/tb_sram_2p_bw_model.sv
// Directed bench for sram_2p_bw_model: three instances (RD_LAT=1, RD_LAT=3, DEPTH=48).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_sram_2p_bw_model;

    localparam int DW = 64;

    logic inst_clk;
    logic inst_rst_n;

    int n_vec;
    int n_err;

    sram_2p_bw_model_if #(.DATA_WIDTH(DW), .DEPTH(64)) bus1 ();
    sram_2p_bw_model_if #(.DATA_WIDTH(DW), .DEPTH(64)) bus3 ();
    sram_2p_bw_model_if #(.DATA_WIDTH(DW), .DEPTH(48)) bus48 ();

    sram_2p_bw_model #(.DATA_WIDTH(DW), .DEPTH(64), .RD_LAT(1)) u_dut1 (
        .inst_clk (inst_clk), .inst_rst_n (inst_rst_n), .bus (bus1.slave));
    sram_2p_bw_model #(.DATA_WIDTH(DW), .DEPTH(64), .RD_LAT(3)) u_dut3 (
        .inst_clk (inst_clk), .inst_rst_n (inst_rst_n), .bus (bus3.slave));
    sram_2p_bw_model #(.DATA_WIDTH(DW), .DEPTH(48), .RD_LAT(1)) u_dut48 (
        .inst_clk (inst_clk), .inst_rst_n (inst_rst_n), .bus (bus48.slave));

    initial inst_clk = 1'b0;
    always #5 inst_clk = ~inst_clk;

    task automatic chk_vec(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge inst_clk);
        #1;
    endtask

    task automatic idle;
        bus1.inst_wr_cs_n  = 1'b1; bus1.inst_rd_cs_n  = 1'b1;
        bus3.inst_wr_cs_n  = 1'b1; bus3.inst_rd_cs_n  = 1'b1;
        bus48.inst_wr_cs_n = 1'b1; bus48.inst_rd_cs_n = 1'b1;
    endtask

    task automatic wr(input int sel, input logic [5:0] a, input logic [DW-1:0] d, input logic [7:0] be);
        case (sel)
            1: begin
                bus1.inst_wr_cs_n = 1'b0; bus1.inst_wr_addr = a;
                bus1.inst_wr_data = d;    bus1.inst_wr_be   = be;
            end
            3: begin
                bus3.inst_wr_cs_n = 1'b0; bus3.inst_wr_addr = a;
                bus3.inst_wr_data = d;    bus3.inst_wr_be   = be;
            end
            default: begin
                bus48.inst_wr_cs_n = 1'b0; bus48.inst_wr_addr = a;
                bus48.inst_wr_data = d;    bus48.inst_wr_be   = be;
            end
        endcase
    endtask

    task automatic rd(input int sel, input logic [5:0] a);
        case (sel)
            1:       begin bus1.inst_rd_cs_n  = 1'b0; bus1.inst_rd_addr  = a; end
            3:       begin bus3.inst_rd_cs_n  = 1'b0; bus3.inst_rd_addr  = a; end
            default: begin bus48.inst_rd_cs_n = 1'b0; bus48.inst_rd_addr = a; end
        endcase
    endtask

    initial begin
        int vld_seen;
        logic [DW-1:0] exp_col;
        n_vec = 0;
        n_err = 0;
        idle();
        bus1.inst_wr_addr = '0;  bus1.inst_wr_data = '0;  bus1.inst_wr_be = '0;  bus1.inst_rd_addr = '0;
        bus3.inst_wr_addr = '0;  bus3.inst_wr_data = '0;  bus3.inst_wr_be = '0;  bus3.inst_rd_addr = '0;
        bus48.inst_wr_addr = '0; bus48.inst_wr_data = '0; bus48.inst_wr_be = '0; bus48.inst_rd_addr = '0;
        inst_rst_n = 1'b0;
        step(); step();
        chk_vec("rst_vld1",  64'(bus1.data_out_vld), 64'd0);
        chk_vec("rst_dat1",  bus1.data_out_inst,     64'd0);
        chk_vec("rst_err1",  64'(bus1.addr_err),     64'd0);
        chk_vec("rst_vld3",  64'(bus3.data_out_vld), 64'd0);
        inst_rst_n = 1'b1;
        step();

        // Basic write/read with RD_LAT=1: sample at T, result after T+1
        wr(1, 6'd3, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF); step(); idle();
        rd(1, 6'd3); step(); idle();
        chk_vec("t1_vld_T",   64'(bus1.data_out_vld), 64'd0);
        step();
        chk_vec("t1_vld",     64'(bus1.data_out_vld), 64'd1);
        chk_vec("t1_dat",     bus1.data_out_inst,     64'hA5A5_A5A5_A5A5_A5A5);
        step();
        chk_vec("t1_vld_off", 64'(bus1.data_out_vld), 64'd0);
        chk_vec("t1_hold",    bus1.data_out_inst,     64'hA5A5_A5A5_A5A5_A5A5);

        // Byte mask 0x05 updates bytes 0 and 2 only
        wr(1, 6'd5, 64'h1111_1111_1111_1111, 8'hFF); step();
        wr(1, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h05); step(); idle();
        rd(1, 6'd5); step(); idle(); step();
        chk_vec("t2_vld", 64'(bus1.data_out_vld), 64'd1);
        chk_vec("t2_dat", bus1.data_out_inst,     64'h1111_1111_11FF_11FF);

        // Same-cycle write and read at addr 7
        wr(1, 6'd7, 64'h2222_2222_2222_2222, 8'hFF); step();
        wr(1, 6'd7, 64'h3333_3333_3333_3333, 8'h01); rd(1, 6'd7); step(); idle(); step();
`ifdef SRAM_WR_FWD_EN
        exp_col = 64'h2222_2222_2222_2233;
`else
        exp_col = 64'h2222_2222_2222_2222;
`endif
        chk_vec("t4_col_vld", 64'(bus1.data_out_vld), 64'd1);
        chk_vec("t4_col_dat", bus1.data_out_inst,     exp_col);
        rd(1, 6'd7); step(); idle(); step();
        chk_vec("t4_commit",  bus1.data_out_inst,     64'h2222_2222_2222_2233);
        chk_vec("t4_err1",    64'(bus1.addr_err),     64'd0);

        // RD_LAT=3: back-to-back reads, one result per cycle in order
        wr(3, 6'd0, 64'h0101_0101_0101_0101, 8'hFF); step();
        wr(3, 6'd1, 64'h0202_0202_0202_0202, 8'hFF); step();
        wr(3, 6'd2, 64'h0303_0303_0303_0303, 8'hFF); step(); idle();
        rd(3, 6'd0); step();
        rd(3, 6'd1); step();
        rd(3, 6'd2); step(); idle();
        chk_vec("t3_vld_T2", 64'(bus3.data_out_vld), 64'd0);
        step();
        chk_vec("t3_vld0", 64'(bus3.data_out_vld), 64'd1);
        chk_vec("t3_dat0", bus3.data_out_inst,     64'h0101_0101_0101_0101);
        step();
        chk_vec("t3_vld1", 64'(bus3.data_out_vld), 64'd1);
        chk_vec("t3_dat1", bus3.data_out_inst,     64'h0202_0202_0202_0202);
        step();
        chk_vec("t3_vld2", 64'(bus3.data_out_vld), 64'd1);
        chk_vec("t3_dat2", bus3.data_out_inst,     64'h0303_0303_0303_0303);
        step();
        chk_vec("t3_end",  64'(bus3.data_out_vld), 64'd0);

        // DEPTH=48: out-of-range write/read; addr 18 aliases 50 in the low bits
        wr(0, 6'd18, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF); step(); idle();
        chk_vec("t5_err_pre", 64'(bus48.addr_err), 64'd0);
        wr(0, 6'd50, 64'h7777_7777_7777_7777, 8'hFF); step(); idle();
        chk_vec("t5_err_wr", 64'(bus48.addr_err), 64'd1);
        rd(0, 6'd50); step(); idle(); step();
        chk_vec("t5_oob_vld", 64'(bus48.data_out_vld), 64'd1);
        chk_vec("t5_oob_dat", bus48.data_out_inst,     64'd0);
        rd(0, 6'd18); step(); idle(); step();
        chk_vec("t5_alias",   bus48.data_out_inst,     64'h5A5A_5A5A_5A5A_5A5A);
        chk_vec("t5_sticky",  64'(bus48.addr_err),     64'd1);

        // Reset with a RD_LAT=3 read in flight
        rd(3, 6'd1); step(); idle(); step();
        inst_rst_n = 1'b0;
        #2;
        chk_vec("t6_err48_rst", 64'(bus48.addr_err), 64'd0);
        step();
        inst_rst_n = 1'b1;
        vld_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus3.data_out_vld === 1'b1) vld_seen++;
        end
        chk_vec("t6_no_vld", 64'(vld_seen),       64'd0);
        chk_vec("t6_dat",    bus3.data_out_inst,  64'd0);
        chk_vec("t6_err48",  64'(bus48.addr_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
